// File: rtl/rv32_d_imm_stage_pkg.sv
// Shared types for the decode-side immediate generation stage.
// Immediate format encoding and the skid-buffer occupancy states.
// Imported by the decode sub-module, the stage interface and the stage top.
package rv32_pkg;

  // Immediate format selector carried with each decoded instruction.
  typedef enum logic [2:0] {
    IMM_I       = 3'b000,
    IMM_S       = 3'b001,
    IMM_B       = 3'b010,
    IMM_J       = 3'b011,
    IMM_U       = 3'b100,
    IMM_ZIMM    = 3'b101,
    IMM_SHAMT   = 3'b110,
    IMM_ILLEGAL = 3'b111
  } imm_src_e;

  // Occupancy of the output register plus skid register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/rv32_d_imm_stage_if.sv
// Decode-to-issue handshake bundle: upstream instruction fields and downstream immediate result.
// master = side that produces instructions and consumes results; slave = the immediate stage.
// Valid/ready on both directions; ready is only meaningful together with valid.
interface rv32_d_imm_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  import rv32_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:7]      in_instr;
  imm_src_e         in_imm_src;
  logic [XLEN-1:0]  in_pc;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [XLEN-1:0]  out_target;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_imm_src, in_pc, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_pc, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_tag, out_illegal
  );

endinterface

// File: rtl/rv32_d_imm_stage_decode.sv
// Immediate extraction and sign/zero extension for all RV immediate formats.
// Latency: purely combinational.
// Backpressure: none; the enclosing stage owns all flow control.
module rv32_d_imm_decode
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_src_e        src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Signed casts sign-extend from the format's top bit; unsigned casts zero-extend.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (src)
      IMM_I:     imm = XLEN'($signed(instr[31:20]));
      IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_ZIMM:  imm = XLEN'(instr[19:15]);
      IMM_SHAMT: begin
        // RV64 shifts use a 6-bit amount; RV32 only 5.
        if (XLEN == 64) imm = XLEN'(instr[25:20]);
        else            imm = XLEN'(instr[24:20]);
      end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_d_imm_stage.sv
// Registered immediate stage: decodes immediate, computes pc+imm, holds result for issue.
// Latency 1 cycle, throughput 1/cycle through a 2-entry (output + skid) buffer.
// in_ready depends only on registered state (low when skid occupied); flush empties both entries.
module rv32_d_imm_stage
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  rv32_d_imm_stage_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } imm_entry_t;

  stage_state_e    state_q, state_d;
  imm_entry_t      main_q, skid_q, new_entry;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            pc_only;
  logic            in_fire, out_fire;
  logic            load_main, load_skid, main_from_skid;

  rv32_d_imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (bus.in_instr),
    .src     (bus.in_imm_src),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Non-address formats report the bare pc as their target.
  assign pc_only = (bus.in_imm_src == IMM_ZIMM) || (bus.in_imm_src == IMM_SHAMT) ||
                   (bus.in_imm_src == IMM_ILLEGAL);

  assign new_entry.imm     = dec_imm;
  assign new_entry.target  = pc_only ? bus.in_pc : bus.in_pc + dec_imm;
  assign new_entry.tag     = bus.in_tag;
  assign new_entry.illegal = dec_illegal;

  assign bus.in_ready    = (state_q != ST_FULL);
  assign bus.out_valid   = (state_q != ST_EMPTY);
  assign bus.out_imm     = main_q.imm;
  assign bus.out_target  = main_q.target;
  assign bus.out_tag     = main_q.tag;
  assign bus.out_illegal = main_q.illegal;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  // Occupancy state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  // Next occupancy and which register captures what; flush overrides every handshake.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d        = ST_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d        = ST_EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // Entry storage; the output register only changes on a load, so fields hold under stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_from_skid) main_q <= skid_q;
      else if (load_main) main_q <= new_entry;
      if (load_skid)      skid_q <= new_entry;
    end
  end

endmodule
